// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter unit.
package pc_pkg;

  localparam int PC_W_DEF      = 16;
  localparam int PC_INC_DEF    = 1;
  localparam int RESET_VEC_DEF = 0;
  localparam int RAS_DEPTH_DEF = 4;

  // Next-PC source, resolved once per cycle by the priority select.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET,
    SEL_HOLD
  } npc_sel_e;

endpackage

// File: rtl/pc_ctrl_if.sv
// Control/status bundle between decode/branch logic and the PC unit.
interface pc_ctrl_if #(
  parameter int PC_W = 16
) ();

  logic            stall;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jump;
  logic            call;
  logic            ret;
  logic [PC_W-1:0] jmp_target;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_next_seq;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_ovf;
  logic            ras_unf;

  // Decode side: drives control, observes PC and RAS status.
  modport master (
    output stall, br_taken, br_target, jump, call, ret, jmp_target,
    input  pc, pc_next_seq, ras_empty, ras_full, ras_ovf, ras_unf
  );

  // PC unit side.
  modport slave (
    input  stall, br_taken, br_target, jump, call, ret, jmp_target,
    output pc, pc_next_seq, ras_empty, ras_full, ras_ovf, ras_unf
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack. When full, a push overwrites the oldest
// entry, which is the slot the write pointer already points at.
module pc_ras #(
  parameter int PC_W      = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ptr_q is the next write slot; the top entry sits one below it.
  logic [PC_W-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_o   = mem_q[ptr_q - PTR_W'(1)];

  // Next pointer/count; push and pop are never requested together.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push_i) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is never reset; it is only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter unit: priority next-PC select, PC register, RAS and
// sticky overflow/underflow flags.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int PC_INC    = PC_INC_DEF,
  parameter int RESET_VEC = RESET_VEC_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input logic        clk,
  input logic        reset,
  pc_ctrl_if.slave   bus
);

  localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] RST = PC_W'(RESET_VEC);

  npc_sel_e        sel;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] seq;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty, ras_full;
  logic            push, pop;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  assign seq = pc_q + INC;

  // Priority select: stall > ret > call > jump > branch > sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (bus.stall)         sel = SEL_HOLD;
    else if (bus.ret)      sel = SEL_RET;
    else if (bus.call)     sel = SEL_CALL;
    else if (bus.jump)     sel = SEL_JMP;
    else if (bus.br_taken) sel = SEL_BR;
  end

  // Next PC, RAS requests and sticky flag updates for the selected source.
  always_comb begin
    pc_d  = seq;
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = ovf_q;
    unf_d = unf_q;
    unique case (sel)
      SEL_HOLD: pc_d = pc_q;
      SEL_RET: begin
        if (ras_empty) begin
          pc_d  = seq;
          unf_d = 1'b1;
        end else begin
          pc_d = ras_top;
          pop  = 1'b1;
        end
      end
      SEL_CALL: begin
        pc_d = bus.jmp_target;
        push = 1'b1;
        if (ras_full) ovf_d = 1'b1;
      end
      SEL_JMP: pc_d = bus.jmp_target;
      SEL_BR:  pc_d = bus.br_target;
      default: pc_d = seq;
    endcase
  end

  // PC register and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RST;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (seq),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full)
  );

  assign bus.pc          = pc_q;
  assign bus.pc_next_seq = seq;
  assign bus.ras_empty   = ras_empty;
  assign bus.ras_full    = ras_full;
  assign bus.ras_ovf     = ovf_q;
  assign bus.ras_unf     = unf_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with hand-computed expected PC/flag values.
module tb_pc_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_ctrl_if #(.PC_W(16)) bus ();

  pc_ctrl #(
    .PC_W(16), .PC_INC(1), .RESET_VEC(0), .RAS_DEPTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.stall = 0; bus.br_taken = 0; bus.jump = 0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic go_to(input logic [15:0] a);
    idle(); bus.jump = 1; bus.jmp_target = a; tick(); idle();
  endtask

  task automatic do_call(input logic [15:0] t);
    idle(); bus.call = 1; bus.jmp_target = t; tick(); idle();
  endtask

  task automatic do_ret();
    idle(); bus.ret = 1; tick(); idle();
  endtask

  task automatic flags(input string tag, input logic e, input logic f, input logic o, input logic u);
    chk({tag, "_empty"}, 32'(bus.ras_empty), 32'(e));
    chk({tag, "_full"},  32'(bus.ras_full),  32'(f));
    chk({tag, "_ovf"},   32'(bus.ras_ovf),   32'(o));
    chk({tag, "_unf"},   32'(bus.ras_unf),   32'(u));
  endtask

  initial begin
    idle();
    bus.br_target = '0; bus.jmp_target = '0;
    reset = 1;
    tick(); tick();
    // 1: reset state then sequential fetch
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_seq", 32'(bus.pc_next_seq), 32'h1);
    flags("rst", 1, 0, 0, 0);
    reset = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq_pc", 32'(bus.pc), 32'(i));
    end

    // 2: jump beats branch, then branch alone
    go_to(16'h0010);
    chk("goto10", 32'(bus.pc), 32'h10);
    bus.br_taken = 1; bus.br_target = 16'h0040;
    bus.jump = 1; bus.jmp_target = 16'h0080;
    tick(); idle();
    chk("jmp_over_br", 32'(bus.pc), 32'h80);
    bus.br_taken = 1; bus.br_target = 16'h0040;
    tick(); idle();
    chk("br_only", 32'(bus.pc), 32'h40);

    // 3: nested call/return
    go_to(16'h0005);
    do_call(16'h0100); chk("call1", 32'(bus.pc), 32'h100);
    chk("call1_nempty", 32'(bus.ras_empty), 32'h0);
    do_call(16'h0200); chk("call2", 32'(bus.pc), 32'h200);
    do_ret();          chk("ret1", 32'(bus.pc), 32'h101);
    do_ret();          chk("ret2", 32'(bus.pc), 32'h6);
    flags("chain", 1, 0, 0, 0);

    // 4: overflow then underflow
    go_to(16'h0300);
    do_call(16'h0400);
    do_call(16'h0500);
    do_call(16'h0600);
    do_call(16'h0700);
    flags("full4", 0, 1, 0, 0);
    do_call(16'h0800);
    chk("call5_pc", 32'(bus.pc), 32'h800);
    flags("ovf", 0, 1, 1, 0);
    do_ret(); chk("pop_a5", 32'(bus.pc), 32'h701);
    do_ret(); chk("pop_a4", 32'(bus.pc), 32'h601);
    do_ret(); chk("pop_a3", 32'(bus.pc), 32'h501);
    do_ret(); chk("pop_a2", 32'(bus.pc), 32'h401);
    chk("drained_empty", 32'(bus.ras_empty), 32'h1);
    do_ret(); chk("unf_pc", 32'(bus.pc), 32'h402);
    flags("unf", 1, 0, 1, 1);

    // 5: stall holds PC and RAS, release takes the call once
    reset = 1; tick(); reset = 0;
    flags("rst2", 1, 0, 0, 0);
    go_to(16'h0020);
    bus.stall = 1; bus.call = 1; bus.jmp_target = 16'h0900;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", 32'(bus.pc), 32'h20);
      chk("stall_empty", 32'(bus.ras_empty), 32'h1);
    end
    bus.stall = 0;
    tick(); idle();
    chk("unstall_pc", 32'(bus.pc), 32'h900);
    chk("unstall_nempty", 32'(bus.ras_empty), 32'h0);
    do_ret();
    chk("unstall_ret", 32'(bus.pc), 32'h21);
    chk("unstall_empty", 32'(bus.ras_empty), 32'h1);

    // 6: wrap, then reset together with ret discards the pop
    go_to(16'hFFFF);
    chk("wrap_seqout", 32'(bus.pc_next_seq), 32'h0);
    tick();
    chk("wrap_pc", 32'(bus.pc), 32'h0);
    do_ret();
    chk("unf2_pc", 32'(bus.pc), 32'h1);
    chk("unf2_flag", 32'(bus.ras_unf), 32'h1);
    do_call(16'h0010);
    do_call(16'h0020);
    chk("cnt2_pc", 32'(bus.pc), 32'h20);
    reset = 1; bus.ret = 1;
    tick(); reset = 0; idle();
    chk("rstret_pc", 32'(bus.pc), 32'h0);
    flags("rstret", 1, 0, 0, 0);
    do_ret();
    chk("post_rst_ret_pc", 32'(bus.pc), 32'h1);
    chk("post_rst_ret_unf", 32'(bus.ras_unf), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Parametrised program-counter unit for the single-cycle core. It holds the current PC and selects the next PC each cycle from sequential increment, conditional branch, jump, call or return. It includes a small circular return-address stack (RAS) for call/return. It sits between the decode/branch logic and instruction memory; pc drives the instruction-fetch address.

Parameters:
PC_W, 16, PC width in bits; all PC arithmetic is modulo 2^PC_W.
PC_INC, 1, sequential increment (word-addressed imem).
RESET_VEC, 0, PC value loaded on reset.
RAS_DEPTH, 4, number of return-address entries (power of 2, >=2).

Ports:
clk  in  1  clock, rising-edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  hold PC and RAS; all control inputs ignored.
br_taken  in  1  conditional branch resolved taken.
br_target  in  PC_W  branch destination.
jump  in  1  unconditional jump.
call  in  1  jump-and-link: push return address, go to jmp_target.
ret  in  1  return: pop RAS to PC.
jmp_target  in  PC_W  jump/call destination.
pc  out  PC_W  current PC (registered).
pc_next_seq  out  PC_W  pc + PC_INC (combinational; link value for the regfile).
ras_empty  out  1  RAS holds no entries.
ras_full  out  1  RAS holds RAS_DEPTH entries.
ras_ovf  out  1  sticky: a call overwrote the oldest entry.
ras_unf  out  1  sticky: a ret was issued with RAS empty.

Behaviour:
- Reset is synchronous, active-high, on clk: pc=RESET_VEC, RAS count=0, top pointer=0, ras_ovf=0, ras_unf=0. Reset overrides stall and all controls. Reset mid-call/ret discards that cycle's push/pop.
- All state updates on the rising clk edge. pc changes one cycle after the control is sampled. pc_next_seq, ras_empty and ras_full are combinational from state.
- Next-PC priority, highest first: reset > stall > ret > call > jump > br_taken > sequential.
- stall=1: pc, RAS and sticky flags hold.
- ret with count>0: pc <= top entry; count--; top pointer decrements mod RAS_DEPTH.
- ret with count==0: pc <= pc+PC_INC; ras_unf <= 1; RAS unchanged.
- call: push pc+PC_INC, then pc <= jmp_target.
  - If count<RAS_DEPTH: count++.
  - If full: circular overwrite of the oldest entry; count stays RAS_DEPTH; ras_ovf <= 1.
- ret and call in the same cycle: ret wins, call ignored. No push occurs.
- jump: pc <= jmp_target. br_taken: pc <= br_target. Neither touches the RAS.
- Sequential: pc <= pc+PC_INC. Wraps from 2^PC_W-PC_INC to 0 with no flag.
- Sticky flags clear only on reset.
- RAS entries are not reset; contents are only ever read when count>0.

Decomposition:
- Shared package pc_pkg holds:
  - localparam enum NPC_SEL {SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET, SEL_HOLD}.
  - Default PC_W/PC_INC/RESET_VEC constants.
- One sub-module, pc_ras: circular stack with push, pop, top, count, full, empty and overwrite-on-full.
- pc_ctrl contains the priority select and the pc register.

Test Plan:
1. Reset, then 5 idle cycles -> pc = 0,1,2,3,4; flags 0, ras_empty=1.
2. At pc=0x0010 assert br_taken (br_target=0x0040) and jump (jmp_target=0x0080) together -> next pc=0x0080. Next cycle br_taken alone with br_target=0x0040 -> pc=0x0040.
3. Call chain: at pc=0x0005 call 0x0100, at 0x0100 call 0x0200, then ret, ret -> pc sequence 0x0100, 0x0200, 0x0101, 0x0006; ras_empty=1 at end; no flags.
4. Overflow: 5 calls with RAS_DEPTH=4 (return addresses A1..A5), then 5 rets -> pops A5, A4, A3, A2; 5th ret sees count 0, so pc=prev+1; ras_ovf=1 and ras_unf=1.
5. Stall: hold stall=1 for 3 cycles with call asserted at pc=0x0020 -> pc stays 0x0020 and RAS count stays 0. Release with call still asserted -> pc=jmp_target, one push of 0x0021.
6. Wrap and reset mid-operation:
   - pc=0xFFFF sequential -> pc=0x0000.
   - Assert reset together with ret while count=2 -> pc=RESET_VEC, count=0, flags cleared.
